// File: rtl/macc_accum_multibeat.sv
// -----------------------------------------------------------------------------
// macc_accum_multibeat
//
// Multi-beat multiply-accumulate for the CNN conv/dense engines. Each beat
// multiplies NUM_INPUTS signed activation lanes by weight lanes and reduces
// the products in a registered adder tree. The accumulator sums those dot
// products over a window closed by i_last and adds the window's bias, which is
// taken from the window's first beat.
//
// Latency: a beat sampled at edge k reaches the accumulator at edge k+L+1. Its
// window result (when it is the last beat) shows o_valid after edge k+L+2.
// Here L = $clog2(NUM_INPUTS).
//
// Optional feature: define MACC_ACC_SAT_EN to clamp every accumulator add to
// the signed ACC_WIDTH range. When it is not defined, the accumulator wraps.
// In both builds o_ovf flags the overflow.
//
// Ports:
//   clk       clock, all logic on the rising edge
//   rst       synchronous, active-high reset
//   i_data_a  NUM_INPUTS signed activations; lane i at [(i+1)*A_WIDTH-1 : i*A_WIDTH]
//   i_data_b  NUM_INPUTS weights, same packing (signedness from B_SIGNED)
//   i_bias    signed window bias, used from the first beat of a window
//   i_valid   beat valid
//   i_last    final beat of the window (only meaningful with i_valid)
//   o_data    signed window result
//   o_valid   one-cycle pulse per completed window
//   o_beats   valid beats in the reported window, saturating at MAX_BEATS
//   o_ovf     accumulator overflow seen anywhere in the reported window
// -----------------------------------------------------------------------------
module macc_accum_multibeat #(
   parameter int NUM_INPUTS = 20,
   parameter int A_WIDTH    = 8,
   parameter int B_WIDTH    = 8,
   parameter int B_SIGNED   = 0,
   parameter int ACC_WIDTH  = 32,
   parameter int MAX_BEATS  = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [A_WIDTH*NUM_INPUTS-1:0]     i_data_a,
   input  logic [B_WIDTH*NUM_INPUTS-1:0]     i_data_b,
   input  logic signed [ACC_WIDTH-1:0]       i_bias,
   input  logic                              i_valid,
   input  logic                              i_last,
   output logic signed [ACC_WIDTH-1:0]       o_data,
   output logic                              o_valid,
   output logic [$clog2(MAX_BEATS+1)-1:0]    o_beats,
   output logic                              o_ovf
);

   localparam int L   = $clog2(NUM_INPUTS);
   localparam int PW  = A_WIDTH + B_WIDTH + 1;
   localparam int TW  = PW + L;
   localparam int CW  = $clog2(MAX_BEATS + 1);
   localparam int MSB = ACC_WIDTH - 1;

   // ---------------------------------------------------------------------------
   // Multiplier stage (layer 0) and adder tree (layers 1..L). Layer k holds
   // ceil(NUM_INPUTS / 2^k) nodes, and each node is PW+k bits wide. The
   // sideband signals (valid, last, bias) travel with the data of each layer.
   // ---------------------------------------------------------------------------
   for (genvar k = 0; k <= L; k++) begin : g_lvl
      localparam int W    = PW + k;
      localparam int KP   = (k > 0) ? k - 1 : 0;
      localparam int CNT  = (NUM_INPUTS + (1 << k) - 1) >> k;
      localparam int PCNT = (NUM_INPUTS + (1 << KP) - 1) >> KP;

      logic                        vld;
      logic                        lst;
      logic signed [ACC_WIDTH-1:0] bias;

      if (k == 0) begin : g_side
         // NOTE: clocked state is written with non-blocking assignments so every
         // register samples the values from before the edge, whatever the order
         // of the processes.
         always_ff @(posedge clk) begin
            if (rst) vld <= 1'b0;
            else     vld <= i_valid;
         end

         always_ff @(posedge clk) begin
            if (i_valid) begin
               lst  <= i_last;
               bias <= i_bias;
            end
         end
      end else begin : g_side
         always_ff @(posedge clk) begin
            if (rst) vld <= 1'b0;
            else     vld <= g_lvl[k-1].vld;
         end

         always_ff @(posedge clk) begin
            if (g_lvl[k-1].vld) begin
               lst  <= g_lvl[k-1].lst;
               bias <= g_lvl[k-1].bias;
            end
         end
      end

      for (genvar j = 0; j < CNT; j++) begin : g_node
         logic signed [W-1:0] q;

         if (k == 0) begin : g_mul
            logic signed [A_WIDTH-1:0] a_lane;
            logic signed [B_WIDTH:0]   b_lane;
            (* use_dsp = "yes" *) logic signed [PW-1:0] prod;

            // B gets one extra bit, either a zero or a copy of its sign bit.
            // Both operands are then signed and the product fits exactly in PW bits.
            assign a_lane = i_data_a[j*A_WIDTH +: A_WIDTH];
            assign b_lane = {(B_SIGNED != 0) && i_data_b[(j+1)*B_WIDTH-1],
                             i_data_b[j*B_WIDTH +: B_WIDTH]};
            assign prod   = PW'(a_lane) * PW'(b_lane);

            // NOTE: datapath registers have no reset. The valid bits travelling
            // next to them are reset, and those bits decide whether the data is used.
            always_ff @(posedge clk) begin
               if (i_valid) q <= prod;
            end
         end else if (2*j + 1 < PCNT) begin : g_pair
            always_ff @(posedge clk) begin
               if (g_lvl[k-1].vld)
                  q <= W'(g_lvl[k-1].g_node[2*j].q) + W'(g_lvl[k-1].g_node[2*j+1].q);
            end
         end else begin : g_odd
            // An odd node left over at the end of a layer is passed on
            // unchanged, sign-extended by one bit.
            always_ff @(posedge clk) begin
               if (g_lvl[k-1].vld) q <= W'(g_lvl[k-1].g_node[2*j].q);
            end
         end
      end
   end

   logic signed [TW-1:0]        tree_sum;
   logic                        tree_vld;
   logic                        tree_lst;
   logic signed [ACC_WIDTH-1:0] tree_bias;

   assign tree_sum  = g_lvl[L].g_node[0].q;
   assign tree_vld  = g_lvl[L].vld;
   assign tree_lst  = g_lvl[L].lst;
   assign tree_bias = g_lvl[L].bias;

   // ---------------------------------------------------------------------------
   // Accumulator stage
   // ---------------------------------------------------------------------------
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic [CW-1:0]               beats_q;
   logic                        ovf_q;
   logic                        first_q;
   logic                        done_q;

   logic signed [ACC_WIDTH-1:0] s_ext;
   logic signed [ACC_WIDTH-1:0] base;
   logic signed [ACC_WIDTH-1:0] sum_raw;
   logic signed [ACC_WIDTH-1:0] acc_next;
   logic [CW-1:0]               beats_next;
   logic                        add_ovf;
   logic                        ovf_next;

`ifdef MACC_ACC_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

   // NOTE: every output of this block gets a value before any branch is taken,
   // so no path can leave one unassigned and infer a latch.
   always_comb begin
      s_ext      = ACC_WIDTH'(tree_sum);
      base       = first_q ? tree_bias : acc_q;
      sum_raw    = base + s_ext;
      // Signed overflow: the operands have the same sign and the sum's sign differs.
      add_ovf    = (base[MSB] == s_ext[MSB]) && (sum_raw[MSB] != base[MSB]);
      acc_next   = sum_raw;
`ifdef MACC_ACC_SAT_EN
      if (add_ovf) acc_next = base[MSB] ? ACC_MIN : ACC_MAX;
`endif
      ovf_next   = first_q ? add_ovf : (ovf_q | add_ovf);
      beats_next = beats_q + CW'(1);
      if (first_q)
         beats_next = CW'(1);
      else if (beats_q >= CW'(MAX_BEATS))
         beats_next = CW'(MAX_BEATS);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         beats_q <= '0;
         ovf_q   <= 1'b0;
         first_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= tree_vld && tree_lst;
         if (tree_vld) begin
            acc_q   <= acc_next;
            beats_q <= beats_next;
            ovf_q   <= ovf_next;
            first_q <= tree_lst;
         end
      end
   end

   // The output register captures the finished window one cycle after its last
   // add. A following window may already be overwriting acc_q on that same
   // edge, so the capture takes acc_q's value from before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_data  <= '0;
         o_beats <= '0;
         o_ovf   <= 1'b0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= done_q;
         if (done_q) begin
            o_data  <= acc_q;
            o_beats <= beats_q;
            o_ovf   <= ovf_q;
         end
      end
   end

endmodule

// File: tb/tb_macc_accum_multibeat.sv
// -----------------------------------------------------------------------------
// Testbench for macc_accum_multibeat. It drives two instances, both with
// NUM_INPUTS = 4 and L = 2:
//   dut_u : B unsigned, ACC_WIDTH = 32, MAX_BEATS = 64
//   dut_s : B signed,   ACC_WIDTH = 20 (TW + 1), MAX_BEATS = 3
// The stimulus queues a hand-computed expectation for every closing beat. That
// expectation includes the cycle on which o_valid must appear. One monitor per
// instance pops the queue whenever o_valid is high and compares the outputs.
// -----------------------------------------------------------------------------
module tb_macc_accum_multibeat;

   localparam int LAT = 4;   // L + 2 cycles from the sample edge to o_valid

   typedef struct {
      logic signed [31:0] data;
      int                 beats;
      logic               ovf;
      int                 cyc;
   } exp_t;

`ifdef MACC_ACC_SAT_EN
   localparam int EXP_OVF1   = 524287;
   localparam int EXP_STICKY = 524283;
`else
   localparam int EXP_OVF1   = -524288;
   localparam int EXP_STICKY = 524284;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic [31:0]        data_a;
   logic [31:0]        data_b;
   logic signed [31:0] bias_v;
   logic               last;
   logic               valid_u;
   logic               valid_s;

   logic signed [31:0] o_data_u;
   logic               o_valid_u;
   logic [6:0]         o_beats_u;
   logic               o_ovf_u;
   logic signed [19:0] o_data_s;
   logic               o_valid_s;
   logic [1:0]         o_beats_s;
   logic               o_ovf_s;

   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t q_u[$];
   exp_t q_s[$];

   macc_accum_multibeat #(
      .NUM_INPUTS(4), .A_WIDTH(8), .B_WIDTH(8), .B_SIGNED(0),
      .ACC_WIDTH(32), .MAX_BEATS(64)
   ) dut_u (
      .clk(clk), .rst(rst), .i_data_a(data_a), .i_data_b(data_b),
      .i_bias(bias_v), .i_valid(valid_u), .i_last(last),
      .o_data(o_data_u), .o_valid(o_valid_u), .o_beats(o_beats_u), .o_ovf(o_ovf_u)
   );

   macc_accum_multibeat #(
      .NUM_INPUTS(4), .A_WIDTH(8), .B_WIDTH(8), .B_SIGNED(1),
      .ACC_WIDTH(20), .MAX_BEATS(3)
   ) dut_s (
      .clk(clk), .rst(rst), .i_data_a(data_a), .i_data_b(data_b),
      .i_bias(bias_v[19:0]), .i_valid(valid_s), .i_last(last),
      .o_data(o_data_s), .o_valid(o_valid_s), .o_beats(o_beats_s), .o_ovf(o_ovf_s)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rep(input logic [7:0] v);
      return {4{v}};
   endfunction

   // Drives one beat into the selected instance. A closing beat with a nonzero
   // expected beat count queues its expected result.
   task automatic beat(input bit sel_s, input logic [31:0] a, input logic [31:0] b,
                       input logic signed [31:0] bias, input bit lst,
                       input logic signed [31:0] exp_data, input int exp_beats,
                       input bit exp_ovf);
      exp_t e;
      data_a  = a;
      data_b  = b;
      bias_v  = bias;
      last    = lst;
      valid_u = !sel_s;
      valid_s = sel_s;
      @(posedge clk);
      #1;
      valid_u = 1'b0;
      valid_s = 1'b0;
      last    = 1'b0;
      if (lst && exp_beats != 0) begin
         e.data  = exp_data;
         e.beats = exp_beats;
         e.ovf   = exp_ovf;
         e.cyc   = cyc + LAT;
         if (sel_s) q_s.push_back(e);
         else       q_u.push_back(e);
      end
   endtask

   // Idle cycles with junk on the data buses and an optional stray i_last.
   task automatic idle(input int n, input bit stray_last);
      data_a = 32'h7f7f_7f7f;
      data_b = 32'hffff_ffff;
      last   = stray_last;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      last = 1'b0;
   endtask

   task automatic check_reset();
      check("u o_data after reset",  o_data_u,  0);
      check("u o_beats after reset", o_beats_u, 0);
      check("u o_ovf after reset",   o_ovf_u,   0);
      check("u o_valid after reset", o_valid_u, 0);
      check("s o_data after reset",  o_data_s,  0);
      check("s o_beats after reset", o_beats_s, 0);
      check("s o_ovf after reset",   o_ovf_s,   0);
      check("s o_valid after reset", o_valid_s, 0);
   endtask

   always @(negedge clk) begin : mon_u
      exp_t e;
      if (o_valid_u === 1'b1) begin
         if (q_u.size() == 0) begin
            check("u spurious o_valid", o_valid_u, 0);
         end else begin
            e = q_u.pop_front();
            check("u o_data",        o_data_u,  e.data);
            check("u o_beats",       o_beats_u, e.beats);
            check("u o_ovf",         o_ovf_u,   e.ovf);
            check("u o_valid cycle", cyc,       e.cyc);
         end
      end
   end

   always @(negedge clk) begin : mon_s
      exp_t e;
      if (o_valid_s === 1'b1) begin
         if (q_s.size() == 0) begin
            check("s spurious o_valid", o_valid_s, 0);
         end else begin
            e = q_s.pop_front();
            check("s o_data",        o_data_s,  e.data);
            check("s o_beats",       o_beats_s, e.beats);
            check("s o_ovf",         o_ovf_s,   e.ovf);
            check("s o_valid cycle", cyc,       e.cyc);
         end
      end
   end

   initial begin
      rst     = 1'b1;
      data_a  = '0;
      data_b  = '0;
      bias_v  = '0;
      last    = 1'b0;
      valid_u = 1'b0;
      valid_s = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      rst = 1'b0;
      idle(2, 1'b0);

      // Single beat, most negative a times max unsigned b: 4 * -32640
      beat(0, rep(8'h80), rep(8'hff), 0, 1, -130560, 1, 0);
      idle(6, 1'b0);

      // Three beats of S = 0+1+2+3 = 6, bias 100, bubbles with a stray i_last
      beat(0, rep(8'd1), 32'h0302_0100, 100, 0, 0, 0, 0);
      idle(2, 1'b1);
      beat(0, rep(8'd1), 32'h0302_0100, 999, 0, 0, 0, 0);
      beat(0, rep(8'd1), 32'h0302_0100, 999, 1, 118, 3, 0);
      idle(2, 1'b0);

      // Back-to-back windows: A (S=24, bias 0), B (2 x 24, bias -48), C (4 + 7)
      beat(0, rep(8'd2), rep(8'd3), 0,   1, 24, 1, 0);
      beat(0, rep(8'd2), rep(8'd3), -48, 0, 0,  0, 0);
      beat(0, rep(8'd2), rep(8'd3), 77,  1, 0,  2, 0);
      beat(0, rep(8'd1), rep(8'd1), 7,   1, 11, 1, 0);
      idle(2, 1'b0);

      // Signed B: (-1)*(-1) per lane + 5; (-128)*(-1) per lane
      beat(1, rep(8'hff), rep(8'hff), 5, 1, 9,   1, 0);
      beat(1, rep(8'h80), rep(8'hff), 0, 1, 512, 1, 0);

      // Overflow at ACC_WIDTH = 20: max bias + 1
      beat(1, 32'h0000_0001, 32'h0000_0001, 524287, 1, EXP_OVF1, 1, 1);
      // Sticky overflow: overflowing add, then add -4
      beat(1, 32'h0000_0001, 32'h0000_0001, 524287, 0, 0, 0, 0);
      beat(1, rep(8'hff), rep(8'h01), 0, 1, EXP_STICKY, 2, 1);
      // A fresh window starts with the overflow flag clear
      beat(1, 32'h0000_0001, 32'h0000_0001, 0, 1, 1, 1, 0);

      // Beat count saturates at MAX_BEATS = 3 over a 5-beat window
      for (int i = 0; i < 5; i++)
         beat(1, rep(8'd1), rep(8'd1), 0, (i == 4), 20, 3, 0);
      idle(8, 1'b0);

      // Reset while a window (its last beat included) is in flight
      beat(0, rep(8'd1), rep(8'd1), 1000, 0, 0, 0, 0);
      beat(0, rep(8'd1), rep(8'd1), 0,    0, 0, 0, 0);
      beat(0, rep(8'd1), rep(8'd1), 0,    0, 0, 0, 0);
      beat(0, rep(8'd1), rep(8'd1), 0,    1, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset();
      idle(8, 1'b0);
      beat(0, rep(8'd1), rep(8'd1), 50, 1, 54, 1, 0);

      for (int i = 0; i < 60 && (q_u.size() + q_s.size()) != 0; i++)
         @(posedge clk);
      idle(4, 1'b0);
      check("u windows still pending", q_u.size(), 0);
      check("s windows still pending", q_s.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/macc_accum_multibeat.md
Name: macc_accum_multibeat

Overview:
- Parametrised successor to the single-shot 8-bit multiply-accumulate (MACC) unit used by the CNN conv/dense engines.
- Computes NUM_INPUTS parallel products of signed A by B, then sums them in a registered adder tree.
- Accumulates that dot product across a variable number of beats (a window closed by i_last) and adds a per-window bias.
- Lets a layer whose kernel is wider than NUM_INPUTS stream through one instance. Sits between the line-buffer/weight fetch and the requantise stage.

Parameters:
- NUM_INPUTS, 20: product lanes per beat (≥1).
- A_WIDTH, 8: activation width, always signed.
- B_WIDTH, 8: weight width.
- B_SIGNED, 0: 0 = B zero-extended by 1 bit, 1 = B sign-extended by 1 bit.
- ACC_WIDTH, 32: accumulator/output width; must be ≥ PW+L.
- MAX_BEATS, 64: largest window length tracked by o_beats.

Derived values:
- L = $clog2(NUM_INPUTS).
- PW = A_WIDTH+B_WIDTH+1 (product width).
- TW = PW+L (tree width).
- CW = $clog2(MAX_BEATS+1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset: synchronous, active-high.
- i_data_a  in  A_WIDTH*NUM_INPUTS  activations; lane i at [(i+1)*A_WIDTH-1 : i*A_WIDTH].
- i_data_b  in  B_WIDTH*NUM_INPUTS  weights, same lane packing.
- i_bias  in  ACC_WIDTH  signed bias, sampled on the first beat of a window.
- i_valid  in  1  beat valid.
- i_last  in  1  final beat of window; qualified by i_valid.
- o_data  out  ACC_WIDTH  signed window result.
- o_valid  out  1  one-cycle pulse per completed window.
- o_beats  out  CW  valid beats in the reported window, saturating at MAX_BEATS.
- o_ovf  out  1  accumulator overflowed in the reported window; sticky within the window.

Behaviour:
- Reset state: all outputs 0; all pipeline valid bits 0; accumulator 0; first-beat flag 1.
  - rst overrides everything on the same edge. In-flight beats are dropped and no partial o_valid is emitted.
- Stage M (multiply, 1 cycle):
  - When i_valid is high, register the signed PW-bit product of each lane, plus i_last, i_bias and the valid bit.
  - Data registers hold when i_valid is low. The valid bit always follows i_valid.
  - Products are mapped to DSP blocks (use_dsp attribute on the lane multiplier).
- Stage T (adder tree, L cycles):
  - Pairwise registered adds, one layer per cycle, each layer one bit wider.
  - An odd leftover element is registered unchanged (sign-extended) into the next layer.
  - Sideband signals (valid, last, bias) are delayed alongside the data.
  - NUM_INPUTS=1 gives L=0: no tree registers.
- Stage Acc (1 cycle), acting on tree output S (TW bits, sign-extended to ACC_WIDTH) when its valid bit is set:
  - If first-beat flag: acc <= bias + S; beats <= 1; ovf <= overflow of that add.
  - Else: acc <= acc + S; beats <= min(beats+1, MAX_BEATS); ovf <= ovf | overflow.
  - Overflow = signed two's-complement overflow of the ACC_WIDTH add.
  - First-beat flag <= last.
  - If last: o_data <= new acc, o_beats <= new beats, o_ovf <= new ovf, o_valid <= 1. Otherwise o_valid <= 0.
  - o_data, o_beats and o_ovf hold until the next window completes.
- Latency: a beat sampled at edge k reaches the accumulator at edge k+L+1. o_valid for a last beat sampled at edge k is high after edge k+L+2.
  - NUM_INPUTS=20: latency 7 cycles.
- Throughput: one beat per cycle, no backpressure. Downstream must accept every o_valid pulse.
- Bubbles (i_valid low) anywhere in a window: accumulator and counters hold; no effect on the result.
- Single-beat window (first beat also has i_last): o_data = bias + S, o_beats = 1.
- Back-to-back windows: a last beat followed immediately by a new beat starts a fresh window with no dead cycle. o_valid may pulse on consecutive cycles.
- i_last with i_valid low is ignored.
- Wrap behaviour without the optional macro: accumulator wraps modulo 2^ACC_WIDTH; o_ovf still reports the overflow.

Optional Feature:
- Macro MACC_ACC_SAT_EN.
- Defined:
  - Each accumulator add saturates to the signed ACC_WIDTH range (+2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1)) instead of wrapping.
  - Later adds continue from the clamped value.
  - o_ovf still flags any clamp.
- Undefined: wrap-around as above; no saturation logic is synthesised.

Test Plan:
1. NUM_INPUTS=4, B_SIGNED=0, ACC_WIDTH=32. One beat, all a=-128, b=255, bias=0, last=1 -> o_data=-130560, o_beats=1, o_ovf=0, o_valid high exactly L+2=4 cycles after the sample edge.
2. Same configuration. Three beats, a=1, b=lane index (0,1,2,3), bias=100, last on beat 3, with 2 idle cycles inserted between beats 1 and 2 -> single o_valid, o_data=118, o_beats=3.
3. Back-to-back windows of 1 and 2 beats: window A a=2, b=3 (S=24), bias=0; window B S=24 per beat, bias=-48 -> o_valid on 2 cycles; o_data 24 then 0; o_beats 1 then 2.
4. B_SIGNED=1, a=-1, b=-1 on all lanes, last=1, bias=5 -> o_data=9 (NUM_INPUTS=4).
5. ACC_WIDTH=TW+1, bias=+max, then 1 beat with S=+1. Without macro -> o_data=-2^(ACC_WIDTH-1), o_ovf=1. With MACC_ACC_SAT_EN -> o_data=+max, o_ovf=1.
6. Assert rst for 1 cycle while 2 beats of an open window are in the tree -> no o_valid. All outputs read 0 after the reset edge. The next 1-beat window reports bias+S only, with o_beats=1.
